// File: rtl/uart_hex_formatter_pkg.sv
// counter_pkg: shared FSM states, ASCII constants and nibble-to-hex-character mapping
package counter_pkg;
  typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} state_t;
  localparam logic [0:7] ASCII_CR = 8'h0D;
  localparam logic [0:7] ASCII_LF = 8'h0A;
  localparam logic [0:7] ASCII_0 = 8'h30;
  localparam logic [0:7] ASCII_A = 8'h41;
  function automatic logic [0:7] nibble_to_ascii(input logic [0:3] n);
    return (n < 4'd10) ? ASCII_0 + {4'h0, n} : ASCII_A + {4'h0, n} - 8'd10;
  endfunction
endpackage

// File: rtl/uart_hex_formatter_if.sv
// uart_hex_formatter_if: count input, transmitter handshake and status between counter, formatter and UART
interface uart_hex_formatter_if #(parameter int P_WIDTH = 32);
  logic [0:P_WIDTH-1] i_count;
  logic i_count_valid;
  logic o_ready;
  logic [0:7] o_uart_data;
  logic o_start_uart;
  logic i_tx_busy;
  logic o_overrun;
  modport slave (
    input i_count, i_count_valid, i_tx_busy,
    output o_ready, o_uart_data, o_start_uart, o_overrun
  );
  modport master (
    output i_count, i_count_valid, i_tx_busy,
    input o_ready, o_uart_data, o_start_uart, o_overrun
  );
endinterface

// File: rtl/uart_hex_formatter_encoder.sv
// hex_ascii_encoder: combinational 4-bit nibble to uppercase ASCII hex character
module hex_ascii_encoder
  import counter_pkg::*;
(
  input logic [0:3] nib,
  output logic [0:7] ascii
);
  assign ascii = nibble_to_ascii(nib);
endmodule

// File: rtl/uart_hex_formatter.sv
// uart_hex_formatter: sequences a captured count into uppercase hex ASCII bytes for a UART transmitter
module uart_hex_formatter
  import counter_pkg::*;
#(
  parameter int P_WIDTH = 32,
  parameter int P_NEWLINE = 1
) (
  input logic clk,
  input logic i_reset,
  uart_hex_formatter_if.slave bus
);
  localparam int D = P_WIDTH / 4;
  localparam int N = D + 2 * P_NEWLINE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  state_t state;
  logic [0:P_WIDTH-1] shreg, shifted;
  logic [IW-1:0] idx;
  logic [0:3] nib;
  logic [0:7] digit, next_char;
  assign shifted = shreg << 4;
  // in IDLE the first digit comes straight from the incoming count so it is ready on the START cycle
  assign nib = (state == IDLE) ? bus.i_count[0:3] : shifted[0:3];
  hex_ascii_encoder enc (.nib(nib), .ascii(digit));
  always_comb next_char = (int'(idx) + 1 < D) ? digit : (int'(idx) + 1 == D) ? ASCII_CR : ASCII_LF;
  assign bus.o_ready = (state == IDLE);
  assign bus.o_overrun = bus.i_count_valid & ~bus.o_ready;
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= IDLE;
      shreg <= '0;
      idx <= '0;
      bus.o_uart_data <= '0;
      bus.o_start_uart <= 1'b0;
    end else begin
      bus.o_start_uart <= 1'b0;
      case (state)
        IDLE: if (bus.i_count_valid) begin
          shreg <= bus.i_count;
          idx <= '0;
          bus.o_uart_data <= digit;
          bus.o_start_uart <= 1'b1;
          state <= START;
        end
        START: state <= ACK;
        ACK: if (bus.i_tx_busy) state <= DRAIN;
        DRAIN: if (!bus.i_tx_busy) begin
          if (idx == IW'(N - 1)) state <= IDLE;
          else begin
            idx <= idx + 1'b1;
            shreg <= shifted;
            bus.o_uart_data <= next_char;
            bus.o_start_uart <= 1'b1;
            state <= START;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_hex_formatter.sv
// tb_uart_hex_formatter: scoreboard bench with transmitter models for newline and digits-only formatters
module tb_uart_hex_formatter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  uart_hex_formatter_if #(.P_WIDTH(32)) ifa ();
  uart_hex_formatter_if #(.P_WIDTH(32)) ifb ();
  uart_hex_formatter #(.P_WIDTH(32), .P_NEWLINE(1)) dut_a (.clk(clk), .i_reset(rst), .bus(ifa.slave));
  uart_hex_formatter #(.P_WIDTH(32), .P_NEWLINE(0)) dut_b (.clk(clk), .i_reset(rst), .bus(ifb.slave));
  int total = 0, bad = 0;
  logic [7:0] qa[$], qb[$];
  int starts_a = 0, starts_b = 0, ovr_a = 0;
  int rises_a = 0, falls_a = 0, falls_b = 0;
  bit pend_a = 0, hi_a = 0, pend_b = 0, hi_b = 0;
  int rmin = 0, rmax = 0, hmin = 20, hmax = 20;
  int tgt_a = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic void push_line(input bit nl, input logic [31:0] c);
    string hex = "0123456789ABCDEF";
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ch;
      ch = hex[int'((c >> (4 * (7 - i))) & 32'hF)];
      if (nl) qa.push_back(ch);
      else qb.push_back(ch);
    end
    if (nl) begin
      qa.push_back(8'h0D);
      qa.push_back(8'h0A);
    end
  endfunction
  task automatic give_up(input string name);
    bad++;
    $display("FAIL %s: wait bound expired", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "stopped");
  endtask
  task automatic wait_falls_a(input int t);
    int n = 0;
    while (falls_a < t && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (falls_a < t) give_up("wait_falls_a");
  endtask
  task automatic wait_rises_a(input int t);
    int n = 0;
    while (rises_a < t && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (rises_a < t) give_up("wait_rises_a");
  endtask
  task automatic send_a(input logic [31:0] c);
    @(posedge clk); #1;
    check("ready_before_accept", ifa.o_ready, 1);
    ifa.i_count = c;
    ifa.i_count_valid = 1'b1;
    push_line(1'b1, c);
    @(posedge clk); #1;
    ifa.i_count_valid = 1'b0;
    check("start_after_accept", ifa.o_start_uart, 1);
    check("ready_low_after_accept", ifa.o_ready, 0);
  endtask
  initial begin
    int d, h;
    ifa.i_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.o_start_uart === 1'b1) begin
        d = int'($urandom_range(rmax, rmin));
        h = int'($urandom_range(hmax, hmin));
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 ifa.i_tx_busy = 1'b1;
        rises_a++;
        repeat (h) @(posedge clk);
        #1 ifa.i_tx_busy = 1'b0;
        falls_a++;
      end
    end
  end
  initial begin
    ifb.i_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.o_start_uart === 1'b1) begin
        @(posedge clk);
        #1 ifb.i_tx_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 ifb.i_tx_busy = 1'b0;
        falls_b++;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (ifa.o_overrun === 1'b1) ovr_a++;
    if (ifa.o_start_uart === 1'b1) begin
      starts_a++;
      check("protocol_a", pend_a, 0);
      pend_a = 1;
      hi_a = 0;
      check("expected_line_a", qa.size() != 0, 1);
      if (qa.size() != 0) check("byte_a", ifa.o_uart_data, qa.pop_front());
    end else if (pend_a) begin
      if (ifa.i_tx_busy) hi_a = 1;
      else if (hi_a) pend_a = 0;
    end
    if (ifb.o_start_uart === 1'b1) begin
      starts_b++;
      check("protocol_b", pend_b, 0);
      pend_b = 1;
      hi_b = 0;
      check("expected_line_b", qb.size() != 0, 1);
      if (qb.size() != 0) check("byte_b", ifb.o_uart_data, qb.pop_front());
    end else if (pend_b) begin
      if (ifb.i_tx_busy) hi_b = 1;
      else if (hi_b) pend_b = 0;
    end
  end
  initial begin
    int ov, s0, n;
    logic [31:0] c;
    rst = 1'b1;
    ifa.i_count_valid = 1'b0;
    ifa.i_count = '0;
    ifb.i_count_valid = 1'b0;
    ifb.i_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", ifa.o_ready, 1);
    check("rst_start_a", ifa.o_start_uart, 0);
    check("rst_data_a", ifa.o_uart_data, 0);
    check("rst_overrun_a", ifa.o_overrun, 0);
    check("rst_ready_b", ifb.o_ready, 1);
    check("rst_start_b", ifb.o_start_uart, 0);
    check("rst_data_b", ifb.o_uart_data, 0);
    rst = 1'b0;
    send_a(32'h0000_00FF);
    tgt_a += 10;
    wait_falls_a(tgt_a);
    @(posedge clk); #1;
    check("ready_after_line", ifa.o_ready, 1);
    check("starts_ff", starts_a, 10);
    check("queue_empty_ff", qa.size(), 0);
    @(posedge clk); #1;
    ifb.i_count = 32'hDEAD_BEEF;
    ifb.i_count_valid = 1'b1;
    push_line(1'b0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    ifb.i_count_valid = 1'b0;
    n = 0;
    while (falls_b < 8 && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (falls_b < 8) give_up("wait_falls_b");
    repeat (30) @(posedge clk);
    #1;
    check("starts_nl0", starts_b, 8);
    check("queue_empty_nl0", qb.size(), 0);
    check("ready_nl0", ifb.o_ready, 1);
    ov = ovr_a;
    send_a(32'hA5C3_0F19);
    wait_rises_a(tgt_a + 3);
    tgt_a += 10;
    @(posedge clk); #1;
    ifa.i_count = 32'h1234_5678;
    ifa.i_count_valid = 1'b1;
    @(posedge clk); #1;
    ifa.i_count_valid = 1'b0;
    check("overrun_pulse", ovr_a - ov, 1);
    wait_falls_a(tgt_a);
    repeat (40) @(posedge clk);
    #1;
    check("no_second_line", starts_a, 20);
    check("queue_empty_overrun", qa.size(), 0);
    check("ready_after_overrun", ifa.o_ready, 1);
    send_a(32'h0BAD_CAFE);
    wait_rises_a(tgt_a + 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_start", ifa.o_start_uart, 0);
    check("midreset_ready", ifa.o_ready, 1);
    check("midreset_data", ifa.o_uart_data, 0);
    rst = 1'b0;
    qa.delete();
    s0 = starts_a;
    repeat (60) @(posedge clk);
    #1;
    check("no_start_after_reset", starts_a - s0, 0);
    check("busy_done_after_reset", ifa.i_tx_busy, 0);
    tgt_a = falls_a;
    rmin = 0; rmax = 3; hmin = 5; hmax = 40;
    for (int i = 0; i < 150; i++) begin
      send_a($urandom);
      tgt_a += 10;
      wait_falls_a(tgt_a);
    end
    c = $urandom;
    @(posedge clk); #1;
    check("ready_before_hold", ifa.o_ready, 1);
    ifa.i_count_valid = 1'b1;
    ifa.i_count = c;
    push_line(1'b1, c);
    tgt_a += 10;
    @(posedge clk); #1;
    ifa.i_count = ~c;
    for (int l = 1; l < 6; l++) begin
      wait_falls_a(tgt_a);
      c = $urandom;
      @(posedge clk); #1;
      ifa.i_count = c;
      push_line(1'b1, c);
      tgt_a += 10;
      @(posedge clk); #1;
      ifa.i_count = ~c;
    end
    wait_falls_a(tgt_a);
    ifa.i_count_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("queue_empty_hold", qa.size(), 0);
    check("ready_after_hold", ifa.o_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
